// File: rtl/workload_marker_monitor.sv
// workload_marker_monitor
// Watches the firmware checkbits status bus for TAG-prefixed workload
// start/end markers. It walks NUM_WL workloads RERUNS times in order,
// reports the start-to-end latency of every run, and flags ordering
// errors, nesting errors and an overall timeout.
module workload_marker_monitor #(
    parameter int         CHK_W   = 16,
    parameter logic [7:0] TAG     = 8'hAB,
    parameter int         NUM_WL  = 3,
    parameter int         RERUNS  = 3,
    parameter int         CNT_W   = 24,
    parameter int         TIMEOUT = 150000
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic [CHK_W-1:0] checkbits,
    input  logic             clear,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [1:0]       err_code,
    output logic [3:0]       cur_wl,
    output logic [7:0]       cur_iter,
    output logic             lat_valid,
    output logic [3:0]       lat_wl,
    output logic [7:0]       lat_iter,
    output logic [CNT_W-1:0] lat_cycles
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_GAP  = 3'd2,
        ST_DONE = 3'd3,
        ST_FAIL = 3'd4
    } state_t;

    localparam logic [1:0]       ERR_NONE    = 2'd0;
    localparam logic [1:0]       ERR_ORDER   = 2'd1;
    localparam logic [1:0]       ERR_NEST    = 2'd2;
    localparam logic [1:0]       ERR_TIMEOUT = 2'd3;
    localparam logic [3:0]       LAST_WL     = 4'(NUM_WL - 1);
    localparam logic [7:0]       LAST_ITER   = 8'(RERUNS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT);

    state_t             state_reg,      state_next;
    logic [CHK_W-1:0]   prev_chk_reg,   prev_chk_next;
    logic [3:0]         cur_wl_reg,     cur_wl_next;
    logic [7:0]         cur_iter_reg,   cur_iter_next;
    logic [CNT_W-1:0]   lat_cnt_reg,    lat_cnt_next;
    logic [CNT_W-1:0]   timer_reg,      timer_next;
    logic [1:0]         err_code_reg,   err_code_next;
    logic               lat_valid_reg,  lat_valid_next;
    logic [3:0]         lat_wl_reg,     lat_wl_next;
    logic [7:0]         lat_iter_reg,   lat_iter_next;
    logic [CNT_W-1:0]   lat_cycles_reg, lat_cycles_next;

    logic [CHK_W-1:0]   chk_diff;
    logic               chk_changed;
    logic               tag_ok;
    logic               ev_start;
    logic               ev_end;
    logic [3:0]         ev_idx;
    logic               wl_match;
    logic               last_run;
    logic               timer_active;
    logic               timeout_hit;
    logic [CNT_W-1:0]   lat_inc;
    logic [CNT_W-1:0]   timer_inc;
    logic [1:0]         err_event;

    // Per-bit change detect against the previous sample; a held value
    // produces no difference and therefore never re-fires a marker.
    generate
        for (genvar gi = 0; gi < CHK_W; gi++) begin : g_diff
            assign chk_diff[gi] = checkbits[gi] ^ prev_chk_reg[gi];
        end
    endgenerate

    assign chk_changed = |chk_diff;
    assign tag_ok      = (checkbits[15:8] == TAG);
    assign ev_start    = chk_changed && tag_ok && (checkbits[3:0] == 4'h0);
    assign ev_end      = chk_changed && tag_ok && (checkbits[3:0] == 4'h1);
    assign ev_idx      = checkbits[7:4];
    assign wl_match    = (ev_idx == cur_wl_reg);
    assign last_run    = (cur_wl_reg == LAST_WL) && (cur_iter_reg == LAST_ITER);

    // Saturating increments; latency reported at END is the count the
    // END cycle would have produced, i.e. cycles since the START event.
    assign lat_inc   = (lat_cnt_reg == CNT_MAX) ? CNT_MAX : lat_cnt_reg + CNT_W'(1);
    assign timer_inc = (timer_reg == CNT_MAX) ? CNT_MAX : timer_reg + CNT_W'(1);

    // The global timer runs from the first START until DONE or FAIL.
    assign timer_active = (state_reg == ST_RUN) || (state_reg == ST_GAP);
    assign timeout_hit  = (TIMEOUT != 0) && timer_active && (timer_inc >= TIMEOUT_LIM);

    // Next-state, counter and result logic; timeout outranks any marker.
    always_comb begin
        state_next      = state_reg;
        prev_chk_next   = checkbits;
        cur_wl_next     = cur_wl_reg;
        cur_iter_next   = cur_iter_reg;
        lat_cnt_next    = (state_reg == ST_RUN) ? lat_inc : lat_cnt_reg;
        timer_next      = timer_active ? timer_inc : timer_reg;
        err_code_next   = err_code_reg;
        lat_valid_next  = 1'b0;
        lat_wl_next     = lat_wl_reg;
        lat_iter_next   = lat_iter_reg;
        lat_cycles_next = lat_cycles_reg;
        err_event       = ERR_NONE;

        unique case (state_reg)
            ST_IDLE, ST_GAP: begin
                if (timeout_hit) begin
                    err_event = ERR_TIMEOUT;
                end else if (ev_start && wl_match) begin
                    state_next   = ST_RUN;
                    lat_cnt_next = '0;
                    // Only the very first START arms the global timer.
                    if (state_reg == ST_IDLE) begin
                        timer_next = '0;
                    end
                end else if (ev_start || ev_end) begin
                    err_event = ERR_ORDER;
                end
            end
            ST_RUN: begin
                if (timeout_hit) begin
                    err_event = ERR_TIMEOUT;
                end else if (ev_start) begin
                    err_event = ERR_NEST;
                end else if (ev_end) begin
                    if (wl_match) begin
                        lat_valid_next  = 1'b1;
                        lat_wl_next     = cur_wl_reg;
                        lat_iter_next   = cur_iter_reg;
                        lat_cycles_next = lat_inc;
                        if (cur_wl_reg == LAST_WL) begin
                            cur_wl_next   = 4'd0;
                            cur_iter_next = cur_iter_reg + 8'd1;
                        end else begin
                            cur_wl_next   = cur_wl_reg + 4'd1;
                        end
                        state_next = last_run ? ST_DONE : ST_GAP;
                    end else begin
                        err_event = ERR_ORDER;
                    end
                end
            end
            default: begin
                // DONE and FAIL hold until clear or reset.
            end
        endcase

        // Only the first error is recorded in err_code.
        if (err_event != ERR_NONE) begin
            state_next = ST_FAIL;
            if (err_code_reg == ERR_NONE) begin
                err_code_next = err_event;
            end
        end

        // Restart keeps err_code and keeps tracking checkbits so a value
        // held across the clear is not seen as a fresh marker.
        if (clear) begin
            state_next      = ST_IDLE;
            cur_wl_next     = 4'd0;
            cur_iter_next   = 8'd0;
            lat_cnt_next    = '0;
            timer_next      = '0;
            err_code_next   = err_code_reg;
            lat_valid_next  = 1'b0;
            lat_wl_next     = 4'd0;
            lat_iter_next   = 8'd0;
            lat_cycles_next = '0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            state_reg      <= ST_IDLE;
            prev_chk_reg   <= '0;
            cur_wl_reg     <= 4'd0;
            cur_iter_reg   <= 8'd0;
            lat_cnt_reg    <= '0;
            timer_reg      <= '0;
            err_code_reg   <= ERR_NONE;
            lat_valid_reg  <= 1'b0;
            lat_wl_reg     <= 4'd0;
            lat_iter_reg   <= 8'd0;
            lat_cycles_reg <= '0;
        end else begin
            state_reg      <= state_next;
            prev_chk_reg   <= prev_chk_next;
            cur_wl_reg     <= cur_wl_next;
            cur_iter_reg   <= cur_iter_next;
            lat_cnt_reg    <= lat_cnt_next;
            timer_reg      <= timer_next;
            err_code_reg   <= err_code_next;
            lat_valid_reg  <= lat_valid_next;
            lat_wl_reg     <= lat_wl_next;
            lat_iter_reg   <= lat_iter_next;
            lat_cycles_reg <= lat_cycles_next;
        end
    end

    assign busy       = (state_reg == ST_RUN) || (state_reg == ST_GAP);
    assign done       = (state_reg == ST_DONE);
    assign fail       = (state_reg == ST_FAIL);
    assign err_code   = err_code_reg;
    assign cur_wl     = cur_wl_reg;
    assign cur_iter   = cur_iter_reg;
    assign lat_valid  = lat_valid_reg;
    assign lat_wl     = lat_wl_reg;
    assign lat_iter   = lat_iter_reg;
    assign lat_cycles = lat_cycles_reg;

endmodule

// File: tb/tb_workload_marker_monitor.sv
// Testbench for workload_marker_monitor: two instances (default and a
// short NUM_WL=1/RERUNS=2/TIMEOUT=100 variant) share one stimulus stream;
// a marker-level reference model fills per-instance result queues that a
// separate monitor drains whenever lat_valid is seen.
module tb_workload_marker_monitor;

    localparam logic [7:0] TAG = 8'hAB;

    logic        clock = 1'b0;
    logic        resetb;
    logic        clear;
    logic [15:0] checkbits;

    logic        u0_busy, u0_done, u0_fail, u0_lat_valid;
    logic [1:0]  u0_err_code;
    logic [3:0]  u0_cur_wl, u0_lat_wl;
    logic [7:0]  u0_cur_iter, u0_lat_iter;
    logic [23:0] u0_lat_cycles;

    logic        u1_busy, u1_done, u1_fail, u1_lat_valid;
    logic [1:0]  u1_err_code;
    logic [3:0]  u1_cur_wl, u1_lat_wl;
    logic [7:0]  u1_cur_iter, u1_lat_iter;
    logic [23:0] u1_lat_cycles;

    always #5 clock = ~clock;

    workload_marker_monitor u0 (
        .clock(clock), .resetb(resetb), .checkbits(checkbits), .clear(clear),
        .busy(u0_busy), .done(u0_done), .fail(u0_fail), .err_code(u0_err_code),
        .cur_wl(u0_cur_wl), .cur_iter(u0_cur_iter), .lat_valid(u0_lat_valid),
        .lat_wl(u0_lat_wl), .lat_iter(u0_lat_iter), .lat_cycles(u0_lat_cycles)
    );

    workload_marker_monitor #(.NUM_WL(1), .RERUNS(2), .TIMEOUT(100)) u1 (
        .clock(clock), .resetb(resetb), .checkbits(checkbits), .clear(clear),
        .busy(u1_busy), .done(u1_done), .fail(u1_fail), .err_code(u1_err_code),
        .cur_wl(u1_cur_wl), .cur_iter(u1_cur_iter), .lat_valid(u1_lat_valid),
        .lat_wl(u1_lat_wl), .lat_iter(u1_lat_iter), .lat_cycles(u1_lat_cycles)
    );

    typedef struct {
        int wl;
        int iter;
        int cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   checks = 0;
    int   failures = 0;
    int   lat_seen0 = 0;
    int   lat_seen1 = 0;

    // Reference model: one set of run-level bookkeeping per instance.
    int          m_nwl[2] = '{3, 1};
    int          m_rr[2]  = '{3, 2};
    int          m_to[2]  = '{150000, 100};
    logic [15:0] m_prev[2];
    bit          m_started[2], m_inrun[2], m_failed[2], m_done[2];
    int          m_errc[2], m_k[2], m_t[2], m_tfirst[2], m_tstart[2];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_init(int i, bit keep_err, logic [15:0] prev);
        m_prev[i]    = prev;
        m_started[i] = 1'b0;
        m_inrun[i]   = 1'b0;
        m_failed[i]  = 1'b0;
        m_done[i]    = 1'b0;
        m_k[i]       = 0;
        m_t[i]       = 0;
        m_tfirst[i]  = 0;
        m_tstart[i]  = 0;
        if (!keep_err) m_errc[i] = 0;
    endtask

    task automatic model_error(int i, int code);
        m_failed[i] = 1'b1;
        if (m_errc[i] == 0) m_errc[i] = code;
    endtask

    // Apply one sampled checkbits value to the model of instance i.
    task automatic model_edge(int i, logic [15:0] v);
        bit   ev;
        int   idx;
        int   exp_wl;
        exp_t e;
        ev     = (v != m_prev[i]) && (v[15:8] == TAG) && (v[3:0] <= 4'd1);
        idx    = int'(v[7:4]);
        exp_wl = m_k[i] % m_nwl[i];
        m_prev[i] = v;
        if (!m_failed[i] && !m_done[i]) begin
            if (m_started[i] && m_to[i] != 0 && (m_t[i] - m_tfirst[i]) >= m_to[i]) begin
                model_error(i, 3);
            end else if (ev) begin
                if (m_inrun[i]) begin
                    if (v[3:0] == 4'd0) model_error(i, 2);
                    else if (idx != exp_wl) model_error(i, 1);
                    else begin
                        e.wl   = exp_wl;
                        e.iter = m_k[i] / m_nwl[i];
                        e.cyc  = m_t[i] - m_tstart[i];
                        if (i == 0) q0.push_back(e);
                        else        q1.push_back(e);
                        m_k[i]++;
                        m_inrun[i] = 1'b0;
                        if (m_k[i] == m_nwl[i] * m_rr[i]) m_done[i] = 1'b1;
                    end
                end else begin
                    if (v[3:0] == 4'd0 && idx == exp_wl) begin
                        m_inrun[i]  = 1'b1;
                        m_tstart[i] = m_t[i];
                        if (!m_started[i]) begin
                            m_started[i] = 1'b1;
                            m_tfirst[i]  = m_t[i];
                        end
                    end else begin
                        model_error(i, 1);
                    end
                end
            end
        end
        m_t[i]++;
    endtask

    task automatic drive(logic [15:0] v, int n);
        checkbits = v;
        for (int c = 0; c < n; c++) begin
            model_edge(0, v);
            model_edge(1, v);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        resetb    = 1'b0;
        clear     = 1'b0;
        checkbits = 16'h0000;
        @(posedge clock);
        #1;
        resetb = 1'b1;
        model_init(0, 1'b0, 16'h0000);
        model_init(1, 1'b0, 16'h0000);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        model_init(0, 1'b1, checkbits);
        model_init(1, 1'b1, checkbits);
    endtask

    task automatic check_one(string tag, int i, logic busy_a, logic done_a, logic fail_a,
                             logic [1:0] err_a, logic [3:0] wl_a, logic [7:0] it_a);
        chk($sformatf("%s_u%0d_busy", tag, i), int'(busy_a),
            int'(m_started[i] && !m_done[i] && !m_failed[i]));
        chk($sformatf("%s_u%0d_done", tag, i), int'(done_a), int'(m_done[i]));
        chk($sformatf("%s_u%0d_fail", tag, i), int'(fail_a), int'(m_failed[i]));
        chk($sformatf("%s_u%0d_err_code", tag, i), int'(err_a), m_errc[i]);
        chk($sformatf("%s_u%0d_cur_wl", tag, i), int'(wl_a), m_k[i] % m_nwl[i]);
        chk($sformatf("%s_u%0d_cur_iter", tag, i), int'(it_a), m_k[i] / m_nwl[i]);
    endtask

    task automatic check_state(string tag);
        check_one(tag, 0, u0_busy, u0_done, u0_fail, u0_err_code, u0_cur_wl, u0_cur_iter);
        check_one(tag, 1, u1_busy, u1_done, u1_fail, u1_err_code, u1_cur_wl, u1_cur_iter);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_u0_outputs_or"}, int'(u0_busy | u0_done | u0_fail | u0_lat_valid), 0);
        chk({tag, "_u0_err_code"}, int'(u0_err_code), 0);
        chk({tag, "_u0_cur"}, int'({u0_cur_wl, u0_cur_iter}), 0);
        chk({tag, "_u0_lat_fields"}, int'({u0_lat_wl, u0_lat_iter}), 0);
        chk({tag, "_u0_lat_cycles"}, int'(u0_lat_cycles), 0);
        chk({tag, "_u1_outputs_or"}, int'(u1_busy | u1_done | u1_fail | u1_lat_valid), 0);
        chk({tag, "_u1_err_code"}, int'(u1_err_code), 0);
        chk({tag, "_u1_cur"}, int'({u1_cur_wl, u1_cur_iter}), 0);
        chk({tag, "_u1_lat_fields"}, int'({u1_lat_wl, u1_lat_iter}), 0);
        chk({tag, "_u1_lat_cycles"}, int'(u1_lat_cycles), 0);
    endtask

    // Drain any late lat_valid, then compare end state and leftovers.
    task automatic finish_scenario(string tag);
        drive(checkbits, 3);
        check_state(tag);
        chk({tag, "_u0_results_missing"}, q0.size(), 0);
        chk({tag, "_u1_results_missing"}, q1.size(), 0);
        q0.delete();
        q1.delete();
    endtask

    // Monitor: every lat_valid pulse must match the oldest expected result.
    always @(negedge clock) begin
        if (resetb && u0_lat_valid) begin
            lat_seen0++;
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL u0_lat_unexpected actual wl=%0d iter=%0d cycles=%0d required=none",
                         u0_lat_wl, u0_lat_iter, u0_lat_cycles);
            end else begin
                e0 = q0.pop_front();
                $display("u0 lat wl=%0d iter=%0d cycles=%0d (expect %0d/%0d/%0d)",
                         u0_lat_wl, u0_lat_iter, u0_lat_cycles, e0.wl, e0.iter, e0.cyc);
                chk("u0_lat_wl", int'(u0_lat_wl), e0.wl);
                chk("u0_lat_iter", int'(u0_lat_iter), e0.iter);
                chk("u0_lat_cycles", int'(u0_lat_cycles), e0.cyc);
            end
        end
        if (resetb && u1_lat_valid) begin
            lat_seen1++;
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL u1_lat_unexpected actual wl=%0d iter=%0d cycles=%0d required=none",
                         u1_lat_wl, u1_lat_iter, u1_lat_cycles);
            end else begin
                e1 = q1.pop_front();
                $display("u1 lat wl=%0d iter=%0d cycles=%0d (expect %0d/%0d/%0d)",
                         u1_lat_wl, u1_lat_iter, u1_lat_cycles, e1.wl, e1.iter, e1.cyc);
                chk("u1_lat_wl", int'(u1_lat_wl), e1.wl);
                chk("u1_lat_iter", int'(u1_lat_iter), e1.iter);
                chk("u1_lat_cycles", int'(u1_lat_cycles), e1.cyc);
            end
        end
    end

    initial begin
        int          base0;
        int          base1;
        int          gk;
        bit          gin;
        bit          inject;
        int          r;
        logic [15:0] v;

        resetb    = 1'b0;
        clear     = 1'b0;
        checkbits = 16'h0000;
        @(posedge clock);
        #1;
        check_zero("reset");
        resetb = 1'b1;
        model_init(0, 1'b0, 16'h0000);
        model_init(1, 1'b0, 16'h0000);

        // Nominal: three passes over three workloads, 40-cycle holds.
        base0 = lat_seen0;
        for (int p = 0; p < 3; p++) begin
            for (int w = 0; w < 3; w++) begin
                drive({TAG, 4'(w), 4'h0}, 40);
                drive({TAG, 4'(w), 4'h1}, 40);
            end
        end
        finish_scenario("nominal");
        chk("nominal_u0_lat_count", lat_seen0 - base0, 9);
        chk("nominal_u0_done", int'(u0_done), 1);

        // Ordering error, then clear and restart.
        do_reset();
        drive({TAG, 4'h1, 4'h0}, 5);
        finish_scenario("order");
        do_clear();
        drive({TAG, 4'h0, 4'h0}, 10);
        finish_scenario("clear");
        chk("clear_u0_busy", int'(u0_busy), 1);

        // Nesting: second START inside a run.
        do_reset();
        base0 = lat_seen0;
        drive({TAG, 4'h0, 4'h0}, 20);
        drive({TAG, 4'h1, 4'h0}, 20);
        finish_scenario("nest");
        chk("nest_u0_lat_count", lat_seen0 - base0, 0);

        // Timeout on the TIMEOUT=100 instance: not yet after 99, failed at 100.
        do_reset();
        drive({TAG, 4'h0, 4'h0}, 100);
        check_state("timeout_t99");
        drive({TAG, 4'h0, 4'h0}, 1);
        check_state("timeout_t100");
        chk("timeout_u1_err", int'(u1_err_code), 3);
        finish_scenario("timeout");

        // Held marker and non-TAG glitch: one START, one result.
        do_reset();
        base0 = lat_seen0;
        drive({TAG, 4'h0, 4'h0}, 500);
        drive(16'h1234, 5);
        drive({TAG, 4'h0, 4'h1}, 30);
        finish_scenario("held");
        chk("held_u0_lat_count", lat_seen0 - base0, 1);

        // Reset mid-run, then a full short sequence.
        do_reset();
        drive({TAG, 4'h0, 4'h0}, 30);
        drive({TAG, 4'h0, 4'h1}, 30);
        drive({TAG, 4'h1, 4'h0}, 20);
        resetb    = 1'b0;
        checkbits = 16'h0000;
        @(posedge clock);
        #1;
        check_zero("midreset");
        resetb = 1'b1;
        q0.delete();
        q1.delete();
        model_init(0, 1'b0, 16'h0000);
        model_init(1, 1'b0, 16'h0000);
        base1 = lat_seen1;
        for (int p = 0; p < 2; p++) begin
            drive({TAG, 4'h0, 4'h0}, 30);
            drive({TAG, 4'h0, 4'h1}, 30);
        end
        finish_scenario("midreset_rerun");
        chk("midreset_u1_done", int'(u1_done), 1);
        chk("midreset_u1_lat_count", lat_seen1 - base1, 2);

        // Randomised marker streams with glitches and optional bad markers.
        for (int s = 0; s < 6; s++) begin
            do_reset();
            gk     = 0;
            gin    = 1'b0;
            inject = (s % 2) == 1;
            for (int j = 0; j < 24; j++) begin
                r = int'($urandom_range(0, 19));
                if (r < 14 || (!inject && r >= 17)) begin
                    v = {TAG, 4'(gk % 3), gin ? 4'h1 : 4'h0};
                    if (gin) gk++;
                    gin = !gin;
                end else if (r < 16) begin
                    v = 16'($urandom);
                    if (v[15:8] == TAG) v[15:8] = 8'h12;
                end else if (r == 16) begin
                    v = {TAG, 4'($urandom_range(0, 15)), 4'($urandom_range(2, 15))};
                end else begin
                    v = {TAG, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 1))};
                end
                drive(v, int'($urandom_range(1, 30)));
            end
            finish_scenario($sformatf("random%0d", s));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
